// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU ops
//   in the Execute stage. A normal operation takes XLEN+1 cycles from the
//   start cycle to the done pulse. Divide-by-zero and signed overflow finish
//   on the next cycle with a fixed result.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset (0 = reset)
//   i_start   one-cycle start pulse, honoured only in IDLE and only without i_flush
//   i_flush   synchronous abort (branch/jump flush)
//   i_op      funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_a       dividend (rs1), sampled with i_start
//   i_b       divisor  (rs2), sampled with i_start
//   o_busy    Execute stall request; high in the start cycle and while iterating
//   o_done    one-cycle pulse, o_result valid
//   o_result  quotient or remainder, held until the next completed operation
// -----------------------------------------------------------------------------
module div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_start,
   input  logic            i_flush,
   input  logic [1:0]      i_op,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic            o_busy,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);

   localparam int CNT_W = $clog2(XLEN);
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [XLEN-1:0]   dvd_reg, dvd_next;     // dividend shifting out, quotient shifting in
   logic [XLEN-1:0]   rem_reg, rem_next;     // partial remainder
   logic [XLEN-1:0]   dsr_reg, dsr_next;     // divisor magnitude
   logic              op_rem_reg, op_rem_next;
   logic              neg_q_reg, neg_q_next;
   logic              neg_r_reg, neg_r_next;
   logic [XLEN-1:0]   result_reg, result_next;
   logic [XLEN-1:0]   saved_reg, saved_next; // result before the latest DONE entry
   logic              busy_c;

   // ---------------------------------------------------------------------------
   // Operand preparation (IDLE cycle)
   // ---------------------------------------------------------------------------
   logic            is_signed;
   logic            a_neg, b_neg;
   logic [XLEN-1:0] a_abs, b_abs;
   logic            div_zero, sgn_ovf;
   logic [XLEN-1:0] special_res;

   always_comb begin
      is_signed   = ~i_op[0];
      a_neg       = is_signed & i_a[XLEN-1];
      b_neg       = is_signed & i_b[XLEN-1];
      a_abs       = a_neg ? (-i_a) : i_a;
      b_abs       = b_neg ? (-i_b) : i_b;
      div_zero    = (i_b == '0);
      sgn_ovf     = is_signed & (i_a == INT_MIN) & (i_b == '1);
      // b==0: quotient all ones, remainder = raw dividend.
      // Overflow: quotient INT_MIN, remainder 0.
      if (div_zero)
         special_res = i_op[1] ? i_a : '1;
      else
         special_res = i_op[1] ? '0 : INT_MIN;
   end

   // ---------------------------------------------------------------------------
   // One restoring step. rem_reg < dsr_reg always holds, so the shifted value
   // fits in XLEN+1 bits and the top bit of the difference is the borrow.
   // ---------------------------------------------------------------------------
   logic [XLEN:0]   rem_shift, rem_diff;
   logic            qbit;
   logic [XLEN-1:0] rem_iter, quo_iter, final_val;

   always_comb begin
      rem_shift = {rem_reg, dvd_reg[XLEN-1]};
      rem_diff  = rem_shift - {1'b0, dsr_reg};
      qbit      = ~rem_diff[XLEN];
      rem_iter  = qbit ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
      quo_iter  = {dvd_reg[XLEN-2:0], qbit};
      // Sign fix-up applied to the values produced by the final step.
      if (op_rem_reg)
         final_val = neg_r_reg ? (-rem_iter) : rem_iter;
      else
         final_val = neg_q_reg ? (-quo_iter) : quo_iter;
   end

   // ---------------------------------------------------------------------------
   // Next-state / output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      dvd_next    = dvd_reg;
      rem_next    = rem_reg;
      dsr_next    = dsr_reg;
      op_rem_next = op_rem_reg;
      neg_q_next  = neg_q_reg;
      neg_r_next  = neg_r_reg;
      result_next = result_reg;
      saved_next  = saved_reg;
      busy_c      = 1'b0;
      o_done      = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (i_start && !i_flush) begin
               busy_c      = 1'b1;
               op_rem_next = i_op[1];
               neg_q_next  = a_neg ^ b_neg;
               neg_r_next  = a_neg;
               dvd_next    = a_abs;
               dsr_next    = b_abs;
               rem_next    = '0;
               cnt_next    = CNT_W'(XLEN - 1);
               if (div_zero || sgn_ovf) begin
                  state_next  = S_DONE;
                  saved_next  = result_reg;
                  result_next = special_res;
               end else begin
                  state_next = S_CALC;
               end
            end
         end

         S_CALC: begin
            busy_c = 1'b1;
            if (i_flush) begin
               state_next = S_IDLE;
            end else begin
               dvd_next = quo_iter;
               rem_next = rem_iter;
               if (cnt_reg == '0) begin
                  state_next  = S_DONE;
                  saved_next  = result_reg;
                  result_next = final_val;
               end else begin
                  cnt_next = cnt_reg - 1'b1;
               end
            end
         end

         S_DONE: begin
            state_next = S_IDLE;
            // A flush here cancels the result: the pulse is withheld and the
            // result register rolls back to the value it held before entry.
            if (i_flush)
               result_next = saved_reg;
            else
               o_done = 1'b1;
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Gated with reset so the stall drops the moment reset is asserted,
   // even if a start request is still present on the inputs.
   assign o_busy   = busy_c & reset;
   assign o_result = result_reg;

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= S_IDLE;
         cnt_reg    <= '0;
         dvd_reg    <= '0;
         rem_reg    <= '0;
         dsr_reg    <= '0;
         op_rem_reg <= 1'b0;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         result_reg <= '0;
         saved_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         dvd_reg    <= dvd_next;
         rem_reg    <= rem_next;
         dsr_reg    <= dsr_next;
         op_rem_reg <= op_rem_next;
         neg_q_reg  <= neg_q_next;
         neg_r_reg  <= neg_r_next;
         result_reg <= result_next;
         saved_reg  <= saved_next;
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
//   Directed-vector bench for div_unit: hand-computed quotients/remainders,
//   latency, stall behaviour, flush abort, back-to-back starts and mid-op reset.
// -----------------------------------------------------------------------------
module tb_div_unit;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   logic        clk;
   logic        reset;
   logic        i_start;
   logic        i_flush;
   logic [1:0]  i_op;
   logic [31:0] i_a;
   logic [31:0] i_b;
   logic        o_busy;
   logic        o_done;
   logic [31:0] o_result;

   int n_tests = 0;
   int n_fail  = 0;

   div_unit #(.XLEN(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .i_start  (i_start),
      .i_flush  (i_flush),
      .i_op     (i_op),
      .i_a      (i_a),
      .i_b      (i_b),
      .o_busy   (o_busy),
      .o_done   (o_done),
      .o_result (o_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Launch one operation on a falling edge and follow it to its done pulse.
   // Latency is counted in cycles after the start cycle.
   task automatic run_op(input string name, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat);
      int lat;
      int busy_bad;
      bit seen;
      @(negedge clk);
      check({name, "_idle_done"}, {31'd0, o_done}, 32'd0);
      i_op    = op;
      i_a     = a;
      i_b     = b;
      i_start = 1'b1;
      #1;
      check({name, "_busy_start"}, {31'd0, o_busy}, 32'd1);
      @(posedge clk);
      #1;
      i_start = 1'b0;
      i_a     = $urandom;
      i_b     = $urandom;
      lat      = 0;
      busy_bad = 0;
      seen     = 1'b0;
      while (!seen && lat < 60) begin
         @(negedge clk);
         lat++;
         if (o_done)
            seen = 1'b1;
         else if (!o_busy)
            busy_bad++;
      end
      check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      check({name, "_busy_calc"}, 32'(busy_bad), 32'd0);
      check({name, "_busy_done"}, {31'd0, o_busy}, 32'd0);
      check({name, "_result"}, o_result, exp_res);
      $display("[TB] %s a=0x%08h b=0x%08h -> 0x%08h (lat %0d)", name, a, b, o_result, lat);
   endtask

   initial begin
      int done_cnt;
      reset   = 1'b0;
      i_start = 1'b0;
      i_flush = 1'b0;
      i_op    = 2'b00;
      i_a     = '0;
      i_b     = '0;

      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, o_busy}, 32'd0);
      check("rst_done", {31'd0, o_done}, 32'd0);
      check("rst_result", o_result, 32'd0);
      reset = 1'b1;

      // Main function, unsigned and signed
      run_op("divu_100_7",  OP_DIVU, 32'd100,        32'd7,          32'd14,         33);
      run_op("remu_100_7",  OP_REMU, 32'd100,        32'd7,          32'd2,          33);
      run_op("div_m7_2",    OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33);
      run_op("rem_m7_2",    OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33);
      run_op("div_7_m2",    OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33);
      run_op("rem_7_m2",    OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33);

      // Special cases finish the cycle after start
      run_op("div_ovf",     OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
      run_op("rem_ovf",     OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1);
      run_op("div_by0",     OP_DIV,  32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  1);
      run_op("remu_by0",    OP_REMU, 32'h0000_1234,  32'd0,          32'h0000_1234,  1);

      // Unsigned boundaries: no overflow rule for DIVU
      run_op("divu_min_m1", OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33);
      run_op("divu_max_1",  OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33);

      // Flush during CALC: no done pulse, result keeps 0xFFFFFFFF
      @(negedge clk);
      i_op = OP_DIVU; i_a = 32'd100; i_b = 32'd7; i_start = 1'b1;
      @(posedge clk);
      #1 i_start = 1'b0;
      repeat (10) @(negedge clk);
      i_flush = 1'b1;
      #1;
      check("flush_busy_calc", {31'd0, o_busy}, 32'd1);
      @(posedge clk);
      #1 i_flush = 1'b0;
      @(negedge clk);
      check("flush_busy_idle", {31'd0, o_busy}, 32'd0);
      check("flush_done", {31'd0, o_done}, 32'd0);
      check("flush_result", o_result, 32'hFFFF_FFFF);
      done_cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (o_done) done_cnt++;
      end
      check("flush_no_done", 32'(done_cnt), 32'd0);
      check("flush_result_hold", o_result, 32'hFFFF_FFFF);
      $display("[TB] flush divu 100/7 at T+10 -> result 0x%08h, done pulses %0d", o_result, done_cnt);

      // Start and flush together in IDLE is ignored
      @(negedge clk);
      i_start = 1'b1; i_flush = 1'b1;
      #1;
      check("start_flush_busy", {31'd0, o_busy}, 32'd0);
      @(posedge clk);
      #1 begin i_start = 1'b0; i_flush = 1'b0; end
      @(negedge clk);
      check("start_flush_idle", {31'd0, o_busy}, 32'd0);

      // Back-to-back: second start lands in the IDLE cycle after DONE
      run_op("b2b_50_5",    OP_DIVU, 32'd50,         32'd5,          32'd10,         33);
      run_op("b2b_9_4",     OP_DIVU, 32'd9,          32'd4,          32'd2,          33);

      // Reset mid-CALC clears everything immediately
      @(negedge clk);
      i_op = OP_DIVU; i_a = 32'd50; i_b = 32'd5; i_start = 1'b1;
      @(posedge clk);
      #1 i_start = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst_busy", {31'd0, o_busy}, 32'd0);
      check("midrst_done", {31'd0, o_done}, 32'd0);
      check("midrst_result", o_result, 32'd0);
      $display("[TB] reset mid-op -> busy %0b done %0b result 0x%08h", o_busy, o_done, o_result);
      @(negedge clk);
      reset = 1'b1;

      // Recovery after reset
      run_op("post_rst_remu", OP_REMU, 32'd9,        32'd4,          32'd1,          33);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
